apb_timer_pwm_bank: RTL and testbench

APB_TIMER_PWM_BANK -- requirements
Module: apb_timer_pwm_bank

---
 rtl/periph_timer_pkg.sv | 15 +
 rtl/timer_pwm_channel.sv | 65 ++++++
 rtl/apb_timer_pwm_bank.sv | 104 ++++++++++
 tb/tb_apb_timer_pwm_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_timer_pkg.sv
// periph_timer_pkg: register map constants shared by the timer/PWM bank and its channels
package periph_timer_pkg;
    localparam logic [3:0]  OFF_CTRL       = 4'h0;
    localparam logic [3:0]  OFF_PERIOD     = 4'h4;
    localparam logic [3:0]  OFF_DUTY       = 4'h8;
    localparam logic [3:0]  OFF_COUNT      = 4'hC;
    localparam int          CTRL_EN        = 0;
    localparam int          CTRL_ONESHOT   = 1;
    localparam int          CTRL_POL       = 2;
    localparam logic [11:0] CH_STRIDE      = 12'h010;
    localparam logic [11:0] GLOBAL_BASE    = 12'h100;
    localparam logic [7:0]  OFF_IRQ_STATUS = 8'h00;
    localparam logic [7:0]  OFF_IRQ_EN     = 8'h04;
    localparam logic [7:0]  OFF_PRESCALE   = 8'h08;
endpackage

// File: rtl/timer_pwm_channel.sv
// timer_pwm_channel: one counter with shadowed period/duty, one-shot stop and PWM compare
module timer_pwm_channel
    import periph_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_periph_100mhz,
    input  logic             rst_periph_domain_n_sync,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic             period_we,
    input  logic             duty_we,
    input  logic [31:0]      wdata,
    output logic             en,
    output logic             oneshot,
    output logic             pol,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] duty,
    output logic             wrap,
    output logic             match,
    output logic             pwm
);
    logic [CNT_W-1:0] act_period, act_duty, wval;
    logic             start;

    assign wval  = wdata[CNT_W-1:0];
    assign start = ctrl_we & wdata[CTRL_EN] & ~en;
    assign wrap  = en & tick & (count == act_period);

    // While disabled the active values track the shadows, so an EN rise starts from the latest writes
    always_ff @(posedge clk_periph_100mhz or negedge rst_periph_domain_n_sync) begin
        if (!rst_periph_domain_n_sync) begin
            en         <= 1'b0;
            oneshot    <= 1'b0;
            pol        <= 1'b0;
            count      <= '0;
            period     <= '0;
            duty       <= '0;
            act_period <= '0;
            act_duty   <= '0;
            match      <= 1'b0;
            pwm        <= 1'b0;
        end else begin
            match <= wrap;
            pwm   <= pol ^ (en & (count < act_duty));
            if (period_we) period <= wval;
            if (duty_we) duty <= wval;
            if (!en) begin
                act_period <= period_we ? wval : period;
                act_duty   <= duty_we ? wval : duty;
            end else if (wrap) begin
                act_period <= period;
                act_duty   <= duty;
            end
            count <= (start | wrap) ? '0 : (en & tick) ? count + 1'b1 : count;
            if (wrap & oneshot) en <= 1'b0;
            if (ctrl_we) begin
                en      <= wdata[CTRL_EN];
                oneshot <= wdata[CTRL_ONESHOT];
                pol     <= wdata[CTRL_POL];
            end
        end
    end
endmodule

// File: rtl/apb_timer_pwm_bank.sv
// apb_timer_pwm_bank: zero-wait APB3 bank of timer/PWM channels with shared prescaler and IRQ
module apb_timer_pwm_bank
    import periph_timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              clk_periph_100mhz,
    input  logic              rst_periph_domain_n_sync,
    input  logic [11:0]       apb_paddr,
    input  logic              apb_psel,
    input  logic              apb_penable,
    input  logic              apb_pwrite,
    input  logic [31:0]       apb_pwdata,
    output logic [31:0]       apb_prdata,
    output logic              apb_pready,
    output logic              apb_pslverr,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] ch_match,
    output logic              irq
);
    logic              access, in_glb, in_ch, ch_hit, g_hit, err, ch_we, g_we, any_en, tick;
    logic [3:0]        ch, off;
    logic [7:0]        g_off;
    logic [31:0]       rd;
    logic [NUM_CH-1:0] en, oneshot, pol, wrap, irq_status, irq_en, w1c;
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  duty [NUM_CH];
    logic [PRESC_W-1:0] prescale, presc_cnt;

    assign access = apb_psel & apb_penable;
    assign ch     = apb_paddr[7:4];
    assign off    = apb_paddr[3:0];
    assign g_off  = apb_paddr[7:0];
    assign in_glb = apb_paddr[11:8] == GLOBAL_BASE[11:8];
    assign in_ch  = apb_paddr[11:8] == 4'h0;
    assign ch_hit = in_ch & (int'(ch) < NUM_CH) & (off[1:0] == 2'b00);
    assign g_hit  = in_glb & (g_off == OFF_IRQ_STATUS | g_off == OFF_IRQ_EN | g_off == OFF_PRESCALE);
    assign err    = access & (~(ch_hit | g_hit) | (ch_hit & apb_pwrite & off == OFF_COUNT));
    assign ch_we  = access & apb_pwrite & ~err & ch_hit;
    assign g_we   = access & apb_pwrite & ~err & g_hit;
    assign w1c    = (g_we && g_off == OFF_IRQ_STATUS) ? apb_pwdata[NUM_CH-1:0] : '0;
    assign any_en = |en;
    assign tick   = any_en & (presc_cnt == prescale);

    // Bus outputs are combinational, so they are forced low while reset is held
    assign apb_pready  = access & rst_periph_domain_n_sync;
    assign apb_pslverr = err & rst_periph_domain_n_sync;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        assign sel = ch_we && ch == 4'(c);
        timer_pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_periph_100mhz       (clk_periph_100mhz),
            .rst_periph_domain_n_sync(rst_periph_domain_n_sync),
            .tick                    (tick),
            .ctrl_we                 (sel && off == OFF_CTRL),
            .period_we               (sel && off == OFF_PERIOD),
            .duty_we                 (sel && off == OFF_DUTY),
            .wdata                   (apb_pwdata),
            .en                      (en[c]),
            .oneshot                 (oneshot[c]),
            .pol                     (pol[c]),
            .count                   (count[c]),
            .period                  (period[c]),
            .duty                    (duty[c]),
            .wrap                    (wrap[c]),
            .match                   (ch_match[c]),
            .pwm                     (pwm_out[c])
        );
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch == 4'(i))
                rd = off == OFF_CTRL   ? 32'({pol[i], oneshot[i], en[i]}) :
                     off == OFF_PERIOD ? 32'(period[i]) :
                     off == OFF_DUTY   ? 32'(duty[i]) : 32'(count[i]);
        if (in_glb)
            rd = g_off == OFF_IRQ_STATUS ? 32'(irq_status) :
                 g_off == OFF_IRQ_EN     ? 32'(irq_en) : 32'(prescale);
        apb_prdata = (access && !apb_pwrite && !err && rst_periph_domain_n_sync) ? rd : '0;
    end

    // A hardware wrap in the same cycle as a W1C keeps the status bit set
    always_ff @(posedge clk_periph_100mhz or negedge rst_periph_domain_n_sync) begin
        if (!rst_periph_domain_n_sync) begin
            prescale   <= '0;
            presc_cnt  <= '0;
            irq_en     <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            if (g_we && g_off == OFF_PRESCALE) prescale <= apb_pwdata[PRESC_W-1:0];
            if (g_we && g_off == OFF_IRQ_EN) irq_en <= apb_pwdata[NUM_CH-1:0];
            irq_status <= (irq_status & ~w1c) | wrap;
            irq        <= |(irq_status & irq_en);
            presc_cnt  <= (!any_en || tick) ? '0 : presc_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_timer_pwm_bank.sv
// tb_apb_timer_pwm_bank: register table plus timed sequences for wrap, one-shot, shadowing, W1C and reset
module tb_apb_timer_pwm_bank;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0, prdata;
    logic        pready, pslverr, irq;
    logic [3:0]  pwm_out, ch_match;

    apb_timer_pwm_bank dut (
        .clk_periph_100mhz       (clk),
        .rst_periph_domain_n_sync(rst_n),
        .apb_paddr               (paddr),
        .apb_psel                (psel),
        .apb_penable             (penable),
        .apb_pwrite              (pwrite),
        .apb_pwdata              (pwdata),
        .apb_prdata              (prdata),
        .apb_pready              (pready),
        .apb_pslverr             (pslverr),
        .pwm_out                 (pwm_out),
        .ch_match                (ch_match),
        .irq                     (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int m0[$], m1[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ch_match[0]) m0.push_back(cyc);
        if (ch_match[1]) m1.push_back(cyc);
    end

    int errors = 0, checks = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output logic rdy);
        @(negedge clk);
        psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd = prdata; err = pslverr; rdy = pready;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic e, r;
        apb(1'b1, a, d, rd, e, r);
    endtask

    // Expectation is queued when the access is launched and retired when the access phase is sampled
    task automatic acc(input string name, input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic e, r;
        exp_t x;
        sb.push_back('{name, exp_rd, exp_err});
        apb(w, a, d, rd, e, r);
        x = sb.pop_front();
        chk({x.name, ".pready"}, 32'(r), 32'd1);
        chk({x.name, ".pslverr"}, 32'(e), 32'(x.err));
        if (!w) chk({x.name, ".prdata"}, rd, x.data);
    endtask

    task automatic add(input string n, input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] r, input logic e);
        vt.push_back('{n, w, a, d, r, e});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int t0, n;
        logic [31:0] mact, mexp, pact, pexp;
        logic all_irq;

        repeat (3) @(negedge clk);
        #1;
        chk("rst.pwm_out", 32'(pwm_out), 0);
        chk("rst.ch_match", 32'(ch_match), 0);
        chk("rst.irq", 32'(irq), 0);
        chk("rst.bus", {prdata[29:0], pready, pslverr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        add("rst_ctrl0", 0, 12'h000, 0, 0, 0);
        add("rst_prd3",  0, 12'h034, 0, 0, 0);
        add("rst_pre",   0, 12'h108, 0, 0, 0);
        add("rst_ien",   0, 12'h104, 0, 0, 0);
        add("w_prd0",    1, 12'h004, 32'h1234_5678, 0, 0);
        add("r_prd0",    0, 12'h004, 0, 32'h1234_5678, 0);
        add("w_duty1",   1, 12'h018, 32'hAA, 0, 0);
        add("r_duty1",   0, 12'h018, 0, 32'hAA, 0);
        add("w_ctrl2",   1, 12'h020, 32'hFFFF_FFFC, 0, 0);
        add("r_ctrl2",   0, 12'h020, 0, 32'h4, 0);
        add("w_pre",     1, 12'h108, 32'hFFFF_FF05, 0, 0);
        add("r_pre",     0, 12'h108, 0, 32'h5, 0);
        add("w_ien",     1, 12'h104, 32'hFF, 0, 0);
        add("r_ien",     0, 12'h104, 0, 32'hF, 0);
        add("r_ch4",     0, 12'h040, 0, 0, 1);
        add("w_ch4",     1, 12'h040, 32'h1, 0, 1);
        add("w_cnt",     1, 12'h00C, 32'h5, 0, 1);
        add("r_cnt",     0, 12'h00C, 0, 0, 0);
        add("r_ctrl0b",  0, 12'h000, 0, 0, 0);
        add("r_unal",    0, 12'h00D, 0, 0, 1);
        add("r_g10c",    0, 12'h10C, 0, 0, 1);
        add("r_200",     0, 12'h200, 0, 0, 1);
        add("r_sts",     0, 12'h100, 0, 0, 0);
        for (int i = 0; i < vt.size(); i++)
            acc(vt[i].name, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].err);
        @(negedge clk);
        chk("tbl.pwm_pol", 32'(pwm_out), 32'h4);
        wr(12'h020, 0); wr(12'h108, 0); wr(12'h104, 0);

        // Free-running PWM: period 4 gives a 5-cycle frame, duty 2 gives 2 high cycles
        wr(12'h004, 4); wr(12'h008, 2); wr(12'h000, 1);
        mact = '0; mexp = '0; pact = '0; pexp = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mact[k] = ch_match[0];
            pact[k] = pwm_out[0];
            mexp[k] = (k > 0) && (k % 5 == 0);
            pexp[k] = (k > 0) && ((k - 1) % 5 < 2);
        end
        chk("A.match_train", mact, mexp);
        chk("A.pwm_train", pact, pexp);
        chk("A.irq_masked", 32'(irq), 0);
        acc("A.status", 0, 12'h100, 0, 32'h1, 0);
        wr(12'h000, 0); wr(12'h100, 32'hF);

        // One-shot with prescaler 3: three ticks of four cycles each
        wr(12'h108, 3); wr(12'h004, 2);
        m0.delete();
        wr(12'h000, 32'h3);
        t0 = cyc;
        repeat (40) @(negedge clk);
        chk("B.matches", m0.size(), 1);
        chk("B.first_at", m0.size() > 0 ? m0[0] - t0 : -1, 12);
        acc("B.ctrl", 0, 12'h000, 0, 32'h2, 0);
        acc("B.count", 0, 12'h00C, 0, 0, 0);

        // Period changed mid-count only applies after the current wrap
        wr(12'h108, 0); wr(12'h004, 4);
        m0.delete();
        wr(12'h000, 1);
        t0 = cyc;
        wr(12'h004, 9);
        repeat (20) @(negedge clk);
        chk("C.matches", m0.size(), 2);
        chk("C.wrap1", m0.size() > 0 ? m0[0] - t0 : -1, 5);
        chk("C.wrap2", m0.size() > 1 ? m0[1] - t0 : -1, 15);
        wr(12'h000, 0); wr(12'h100, 32'hF);

        // W1C landing on the same edge as a ch1 wrap must not drop the status bit
        wr(12'h104, 2); wr(12'h014, 4);
        m1.delete();
        wr(12'h010, 1);
        t0 = cyc;
        while (cyc < t0 + 8) begin
            @(posedge clk);
            #1;
        end
        wr(12'h100, 2);
        all_irq = 1'b1;
        repeat (3) begin
            @(negedge clk);
            all_irq &= irq;
        end
        chk("D.wrap_align", m1.size() > 1 ? m1[1] - t0 : -1, 10);
        chk("D.irq_held", 32'(all_irq), 1);
        acc("D.status", 0, 12'h100, 0, 32'h2, 0);
        wr(12'h010, 0); wr(12'h100, 2);
        repeat (2) @(negedge clk);
        chk("D.irq_clear", 32'(irq), 0);
        acc("D.status_clr", 0, 12'h100, 0, 0, 0);

        // Asynchronous reset in the middle of a run with irq raised and a read in progress
        wr(12'h104, 1); wr(12'h004, 4); wr(12'h008, 2); wr(12'h000, 1);
        n = 0;
        while (!irq && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("E.irq_up", 32'(irq), 1);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h104;
        #1;
        chk("E.pre_rd", prdata, 1);
        rst_n = 1'b0;
        #1;
        chk("E.pwm_out", 32'(pwm_out), 0);
        chk("E.ch_match", 32'(ch_match), 0);
        chk("E.irq", 32'(irq), 0);
        chk("E.prdata", prdata, 0);
        chk("E.pready", 32'(pready), 0);
        chk("E.pslverr", 32'(pslverr), 0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc("E.count", 0, 12'h00C, 0, 0, 0);
        acc("E.ctrl", 0, 12'h000, 0, 0, 0);
        mact = '0;
        repeat (10) begin
            @(negedge clk);
            mact |= {ch_match, pwm_out, 3'b0, irq};
        end
        chk("E.quiet", mact, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
